// File: rtl/cache_ctrl_pkg.sv
// Shared types, default geometry and address-field helpers for the cache response controller.
package cache_ctrl_pkg;

  localparam int TAG_W       = 5;
  localparam int IDX_W       = 8;
  localparam int OFF_W       = 3;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = TAG_W + IDX_W + OFF_W;
  localparam int MEM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FILL  = 2'd2,
    RETRY = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-2:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:1];
  endfunction

  // Byte address of word w of the line {tag, idx}.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [OFF_W-2:0] w);
    return {tag, idx, w, 1'b0};
  endfunction

endpackage

// File: rtl/cache_ctrl_next.sv
// Combinational next-state and output decode for the cache response controller.
module cache_ctrl_next
  import cache_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int RET_W   = $clog2(MEM_LAT + 4)
) (
  input  logic               rst,
  input  state_t             state,
  input  logic [1:0]         wcnt,
  input  logic               iss_all,
  input  logic [RET_W-1:0]   rcnt,
  input  logic [MEM_LAT-1:0] rvld,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic [DATA_W-1:0]  DataIn,
  input  logic               Rd,
  input  logic               Wr,
  input  logic               c_hit,
  input  logic               c_dirty,
  input  logic               c_valid,
  input  logic [TAG_W-1:0]   c_tag_out,
  input  logic [DATA_W-1:0]  c_data_out,
  input  logic               c_err,
  input  logic [DATA_W-1:0]  m_data_out,
  input  logic               m_stall,
  input  logic               m_err,
  output state_t             state_n,
  output logic [1:0]         wcnt_n,
  output logic               iss_all_n,
  output logic [RET_W-1:0]   rcnt_n,
  output logic [MEM_LAT-1:0] rvld_n,
  output logic [DATA_W-1:0]  DataOut,
  output logic               Done,
  output logic               Stall,
  output logic               CacheHit,
  output logic               err,
  output logic               c_enable,
  output logic [IDX_W-1:0]   c_index,
  output logic [OFF_W-1:0]   c_offset,
  output logic               c_comp,
  output logic               c_write,
  output logic [TAG_W-1:0]   c_tag_in,
  output logic [DATA_W-1:0]  c_data_in,
  output logic               c_valid_in,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_data_in,
  output logic               m_rd,
  output logic               m_wr
);

  logic               acc;
  logic [MEM_LAT-1:0] rvld_sh;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   idx;
  logic               err_req;

  assign tag = addr_tag(Addr);
  assign idx = addr_idx(Addr);

  // A fill read is accepted when one is still owed and the memory is not busy.
  always_comb acc = !rst && (state == FILL) && !iss_all && !m_stall;

  // In-flight read tracker: bit MEM_LAT-1 marks the cycle a word comes back.
  if (MEM_LAT == 1) begin : g_sh1
    assign rvld_sh = acc;
  end else begin : g_shn
    assign rvld_sh = {rvld[MEM_LAT-2:0], acc};
  end

  // Per-state output decode and next-state selection; everything is quiet during rst.
  always_comb begin
    state_n    = state;
    wcnt_n     = wcnt;
    iss_all_n  = iss_all;
    rcnt_n     = rcnt;
    rvld_n     = rvld;
    DataOut    = '0;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    err_req    = 1'b0;
    c_enable   = 1'b0;
    c_index    = '0;
    c_offset   = '0;
    c_comp     = 1'b0;
    c_write    = 1'b0;
    c_tag_in   = '0;
    c_data_in  = '0;
    c_valid_in = 1'b0;
    m_addr     = '0;
    m_data_in  = '0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    err        = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (Rd || Wr) begin
            if ((Rd && Wr) || Addr[0]) begin
              err_req = 1'b1;
            end else begin
              c_enable = 1'b1;
              c_comp   = 1'b1;
              c_index  = idx;
              c_offset = {addr_word(Addr), 1'b0};
              c_tag_in = tag;
              if (c_hit && c_valid) begin
                Done     = 1'b1;
                CacheHit = 1'b1;
                DataOut  = c_data_out;
                if (Wr) begin
                  c_write   = 1'b1;
                  c_data_in = DataIn;
                end
              end else begin
                Stall     = 1'b1;
                wcnt_n    = 2'd0;
                iss_all_n = 1'b0;
                rcnt_n    = '0;
                rvld_n    = '0;
                state_n   = (c_valid && c_dirty) ? WB : FILL;
              end
            end
          end
        end
        WB: begin
          Stall     = 1'b1;
          c_enable  = 1'b1;
          c_index   = idx;
          c_offset  = {wcnt, 1'b0};
          m_wr      = 1'b1;
          m_addr    = line_addr(c_tag_out, idx, wcnt);
          m_data_in = c_data_out;
          if (!m_stall) begin
            wcnt_n = wcnt + 2'd1;
            if (wcnt == 2'd3) state_n = FILL;
          end
        end
        FILL: begin
          Stall  = 1'b1;
          rvld_n = rvld_sh;
          if (!iss_all) begin
            m_rd   = 1'b1;
            m_addr = line_addr(tag, idx, wcnt);
          end
          if (acc) begin
            wcnt_n    = wcnt + 2'd1;
            iss_all_n = (wcnt == 2'd3);
          end
          if (rvld[MEM_LAT-1]) begin
            c_enable   = 1'b1;
            c_write    = 1'b1;
            c_valid_in = 1'b1;
            c_tag_in   = tag;
            c_index    = idx;
            c_offset   = {rcnt[1:0], 1'b0};
            c_data_in  = m_data_out;
            rcnt_n     = rcnt + RET_W'(1);
            if (rcnt == RET_W'(3)) state_n = RETRY;
          end
        end
        RETRY: begin
          c_enable = 1'b1;
          c_comp   = 1'b1;
          c_index  = idx;
          c_offset = {addr_word(Addr), 1'b0};
          c_tag_in = tag;
          Done     = 1'b1;
          DataOut  = c_data_out;
          if (Wr) begin
            c_write   = 1'b1;
            c_data_in = DataIn;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
      err = err_req || c_err || m_err;
    end
  end

endmodule

// File: rtl/cache_resp_ctrl.sv
// Direct-mapped write-back cache controller: state and counters held here, decode in cache_ctrl_next.
module cache_resp_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err,
  output logic              c_enable,
  output logic [IDX_W-1:0]  c_index,
  output logic [OFF_W-1:0]  c_offset,
  output logic              c_comp,
  output logic              c_write,
  output logic [TAG_W-1:0]  c_tag_in,
  output logic [DATA_W-1:0] c_data_in,
  output logic              c_valid_in,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic              c_valid,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [DATA_W-1:0] c_data_out,
  input  logic              c_err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_rd,
  output logic              m_wr,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic              m_stall,
  input  logic              m_err
);

  localparam int RET_W = $clog2(MEM_LAT + 4);

  state_t             state_p0, state_n;
  logic [1:0]         wcnt_p0, wcnt_n;
  logic               iss_all_p0, iss_all_n;
  logic [RET_W-1:0]   rcnt_p0, rcnt_n;
  logic [MEM_LAT-1:0] rvld_p0, rvld_n;

  cache_ctrl_next #(
    .MEM_LAT (MEM_LAT),
    .RET_W   (RET_W)
  ) u_next (
    .rst        (rst),
    .state      (state_p0),
    .wcnt       (wcnt_p0),
    .iss_all    (iss_all_p0),
    .rcnt       (rcnt_p0),
    .rvld       (rvld_p0),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .Rd         (Rd),
    .Wr         (Wr),
    .c_hit      (c_hit),
    .c_dirty    (c_dirty),
    .c_valid    (c_valid),
    .c_tag_out  (c_tag_out),
    .c_data_out (c_data_out),
    .c_err      (c_err),
    .m_data_out (m_data_out),
    .m_stall    (m_stall),
    .m_err      (m_err),
    .state_n    (state_n),
    .wcnt_n     (wcnt_n),
    .iss_all_n  (iss_all_n),
    .rcnt_n     (rcnt_n),
    .rvld_n     (rvld_n),
    .DataOut    (DataOut),
    .Done       (Done),
    .Stall      (Stall),
    .CacheHit   (CacheHit),
    .err        (err),
    .c_enable   (c_enable),
    .c_index    (c_index),
    .c_offset   (c_offset),
    .c_comp     (c_comp),
    .c_write    (c_write),
    .c_tag_in   (c_tag_in),
    .c_data_in  (c_data_in),
    .c_valid_in (c_valid_in),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_rd       (m_rd),
    .m_wr       (m_wr)
  );

  // State and counter registers; rst abandons any in-flight line operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= IDLE;
      wcnt_p0    <= 2'd0;
      iss_all_p0 <= 1'b0;
      rcnt_p0    <= '0;
      rvld_p0    <= '0;
    end else begin
      state_p0   <= state_n;
      wcnt_p0    <= wcnt_n;
      iss_all_p0 <= iss_all_n;
      rcnt_p0    <= rcnt_n;
      rvld_p0    <= rvld_n;
    end
  end

endmodule

// File: tb/tb_cache_resp_ctrl.sv
// Directed bench for cache_resp_ctrl with behavioural cache array and pipelined memory models.
module tb_cache_resp_ctrl;
  import cache_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, tb_init;
  logic [15:0]       Addr, DataIn;
  logic              Rd, Wr;
  logic [15:0]       DataOut;
  logic              Done, Stall, CacheHit, err;
  logic              c_enable, c_comp, c_write, c_valid_in;
  logic [7:0]        c_index;
  logic [2:0]        c_offset;
  logic [4:0]        c_tag_in, c_tag_out;
  logic [15:0]       c_data_in, c_data_out;
  logic              c_hit, c_dirty, c_valid, c_err;
  logic [15:0]       m_addr, m_data_in, m_data_out;
  logic              m_rd, m_wr, m_stall, m_err;

  cache_resp_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .c_enable(c_enable), .c_index(c_index), .c_offset(c_offset), .c_comp(c_comp),
    .c_write(c_write), .c_tag_in(c_tag_in), .c_data_in(c_data_in), .c_valid_in(c_valid_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
    .c_data_out(c_data_out), .c_err(c_err),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
    .m_data_out(m_data_out), .m_stall(m_stall), .m_err(m_err)
  );

  // Cache array model
  logic [4:0]  ctag   [0:255];
  logic        cval   [0:255];
  logic        cdirty [0:255];
  logic [15:0] cdat   [0:1023];

  assign c_tag_out  = ctag[c_index];
  assign c_valid    = cval[c_index];
  assign c_dirty    = cdirty[c_index];
  assign c_data_out = cdat[{c_index, c_offset[2:1]}];
  assign c_hit      = (ctag[c_index] == c_tag_in);

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) begin
        ctag[i] <= '0; cval[i] <= 1'b0; cdirty[i] <= 1'b0;
      end
      for (int i = 0; i < 1024; i++) cdat[i] <= '0;
    end else if (c_enable && c_write) begin
      if (c_comp) begin
        if (c_hit && cval[c_index]) begin
          cdat[{c_index, c_offset[2:1]}] <= c_data_in;
          cdirty[c_index] <= 1'b1;
        end
      end else begin
        cdat[{c_index, c_offset[2:1]}] <= c_data_in;
        ctag[c_index]   <= c_tag_in;
        cval[c_index]   <= c_valid_in;
        cdirty[c_index] <= 1'b0;
      end
    end
  end

  // Backing memory: word at byte address a starts as a ^ 16'hA5A5; reads return 2 cycles after acceptance.
  logic [15:0] mem [0:32767];
  logic [1:0]  mp_vld;
  logic [15:0] mp_a0, mp_a1;
  logic [15:0] rd_log [0:127];
  logic [15:0] wr_log_a [0:127];
  logic [15:0] wr_log_d [0:127];
  int          rd_n, wr_n;

  assign m_data_out = mp_vld[1] ? mem[mp_a1[15:1]] : 16'h0000;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'(i << 1) ^ 16'hA5A5;
      mp_vld <= 2'b00;
      rd_n   <= 0;
      wr_n   <= 0;
    end else begin
      if (m_wr && !m_stall) begin
        mem[m_addr[15:1]] <= m_data_in;
        wr_log_a[wr_n[6:0]] <= m_addr;
        wr_log_d[wr_n[6:0]] <= m_data_in;
        wr_n <= wr_n + 1;
      end
      if (m_rd && !m_stall) begin
        rd_log[rd_n[6:0]] <= m_addr;
        rd_n <= rd_n + 1;
      end
      mp_vld <= {mp_vld[0], m_rd && !m_stall};
      mp_a0  <= m_addr;
      mp_a1  <= mp_a0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return {6'b0, Done, Stall, CacheHit, err, c_enable, c_comp, c_write, c_valid_in, m_rd, m_wr, DataOut};
  endfunction

  function automatic logic [31:0] addr_vec();
    return {m_addr, c_index, c_offset, c_tag_in};
  endfunction

  // One request from the requester side; checks Stall every waiting cycle and the Done-cycle results.
  task automatic req(input string tag, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input int exp_cyc, input logic exp_hit,
                     input logic [15:0] exp_dout, input int st_from, input int st_len);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    while (cyc <= 40 && !seen) begin
      m_stall = (cyc >= st_from) && (cyc < st_from + st_len);
      #1;
      if (Done === 1'b1) begin
        seen = 1'b1;
        check({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " hit"}, 32'(CacheHit), 32'(exp_hit));
        check({tag, " dataout"}, 32'(DataOut), 32'(exp_dout));
        check({tag, " stall at done"}, 32'(Stall), 32'(0));
      end else begin
        check({tag, " stall"}, 32'(Stall), 32'(1));
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " completed"}, 32'(seen), 32'(1));
    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0; m_stall = 1'b0;
    #1;
    check({tag, " done pulse"}, 32'(Done), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; tb_init = 1'b1;
    Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
    m_stall = 1'b0; m_err = 1'b0; c_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset ctl", ctl_vec(), 32'h0);
    check("reset addr", addr_vec(), 32'h0);
    @(negedge clk);
    rst = 1'b0; tb_init = 1'b0;

    // Cold read fills the line 0x0010..0x0016
    base = rd_n;
    req("cold rd 0010", 1'b1, 1'b0, 16'h0010, 16'h0, 7, 1'b0, 16'hA5B5, 99, 0);
    check("cold rd count", 32'(rd_n - base), 32'd4);
    check("cold rd w0", 32'(rd_log[base]),   32'h0010);
    check("cold rd w1", 32'(rd_log[base+1]), 32'h0012);
    check("cold rd w2", 32'(rd_log[base+2]), 32'h0014);
    check("cold rd w3", 32'(rd_log[base+3]), 32'h0016);

    req("hit rd 0012", 1'b1, 1'b0, 16'h0012, 16'h0, 0, 1'b1, 16'hA5B7, 99, 0);
    req("hit wr 0010", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 1'b1, 16'hA5B5, 99, 0);

    // Dirty conflict miss writes the old line back before filling
    base = rd_n;
    req("dirty rd 0810", 1'b1, 1'b0, 16'h0810, 16'h0, 11, 1'b0, 16'hADB5, 99, 0);
    check("wb count", 32'(wr_n), 32'd4);
    check("wb a0", 32'(wr_log_a[0]), 32'h0010);
    check("wb d0", 32'(wr_log_d[0]), 32'hBEEF);
    check("wb a3", 32'(wr_log_a[3]), 32'h0016);
    check("wb d1", 32'(wr_log_d[1]), 32'hA5B7);
    check("dirty fill w0", 32'(rd_log[base]), 32'h0810);
    check("dirty fill w3", 32'(rd_log[base+3]), 32'h0816);
    req("reload 0010", 1'b1, 1'b0, 16'h0010, 16'h0, 7, 1'b0, 16'hBEEF, 99, 0);

    // Memory busy for three cycles while the fill is issuing
    base = rd_n;
    req("mstall rd 0100", 1'b1, 1'b0, 16'h0100, 16'h0, 10, 1'b0, 16'hA4A5, 2, 3);
    check("mstall count", 32'(rd_n - base), 32'd4);
    check("mstall w1", 32'(rd_log[base+1]), 32'h0102);
    check("mstall w2", 32'(rd_log[base+2]), 32'h0104);
    req("mstall hit 0106", 1'b1, 1'b0, 16'h0106, 16'h0, 0, 1'b1, 16'hA4A3, 99, 0);

    // Protocol errors
    @(negedge clk);
    Rd = 1'b1; Wr = 1'b1; Addr = 16'h0020;
    #1;
    check("rdwr err", 32'(err), 32'd1);
    check("rdwr quiet", 32'({Done, Stall, c_enable, c_write, m_rd, m_wr}), 32'd0);
    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0;
    #1;
    check("rdwr err pulse", 32'(err), 32'd0);
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0021;
    #1;
    check("misalign err", 32'(err), 32'd1);
    check("misalign quiet", 32'({Done, Stall, c_enable, m_rd}), 32'd0);
    @(negedge clk);
    Rd = 1'b0;
    req("after err hit", 1'b1, 1'b0, 16'h0012, 16'h0, 0, 1'b1, 16'hA5B7, 99, 0);
    @(negedge clk);
    m_err = 1'b1;
    #1;
    check("m_err passthru", 32'(err), 32'd1);
    @(negedge clk);
    m_err = 1'b0;

    // Reset during fill word 2
    base = rd_n;
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0040;
    #1;
    check("abort miss stall", 32'(Stall), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst cycle ctl", ctl_vec(), 32'h0);
    @(negedge clk);
    rst = 1'b0; Rd = 1'b0;
    #1;
    check("post rst ctl", ctl_vec(), 32'h0);
    check("post rst addr", addr_vec(), 32'h0);
    check("abort issue count", 32'(rd_n - base), 32'd2);
    req("refill 0040", 1'b1, 1'b0, 16'h0040, 16'h0, 7, 1'b0, 16'hA5E5, 99, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
